// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: operation codes, access sizes, FSM states.
package mem_stage_pkg;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous byte-enabled write, asynchronous read.
module dmem_ram #(
    parameter int S = 15,
    parameter int A = 6
) (
    input  logic         clk,
    input  logic [1:0]   we_i,
    input  logic [A-1:0] idx_i,
    input  logic [S:0]   wdata_i,
    output logic [S:0]   rdata_o
);

    logic [S:0] mem [2**A];

    // Byte-lane write: lane 0 is [7:0], lane 1 is everything above.
    always_ff @(posedge clk) begin
        if (we_i[0]) mem[idx_i][7:0] <= wdata_i[7:0];
        if (we_i[1]) mem[idx_i][S:8] <= wdata_i[S:8];
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: pass-through of ALU results, word/byte load/store against a local
// data RAM with W wait states, stall toward EX/MEM while an access is pending.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int S = 15,
    parameter int C = 1,
    parameter int A = 6,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [1:0]   in_op,
    input  logic         in_size,
    input  logic [S:0]   in_addr,
    input  logic [S:0]   in_wdata,
    input  logic [C:0]   in_ctrl,
    output logic [S:0]   out_word,
    output logic [7:0]   out_byte,
    output logic [C:0]   out_ctrl,
    output logic         out_valid,
    output logic         stall,
    output logic         misalign
);

    localparam bit       ZERO_WS  = (W == 0);
    localparam int       CNT_INIT = (W > 0) ? (W - 1) : 0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Operands captured at accept time for multi-cycle accesses.
    logic [1:0]  op_q;
    logic        size_q;
    logic [S:0]  addr_q, wdata_q;
    logic [C:0]  ctrl_q;

    logic [S:0]  word_q;
    logic [7:0]  byte_q;
    logic [C:0]  octrl_q;
    logic        valid_q, mis_q;

    logic        is_mem_in, accept_mem, accept_pass, do_access;
    logic [1:0]  cur_op;
    logic        cur_size;
    logic [S:0]  cur_addr, cur_wdata;
    logic [C:0]  cur_ctrl;
    logic [1:0]  ram_we;
    logic [S:0]  ram_wdata, ram_rdata;
    logic [7:0]  lane;

    assign is_mem_in   = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign accept_mem  = (state_q == ST_IDLE) && in_valid && is_mem_in;
    assign accept_pass = (state_q == ST_IDLE) && in_valid && !is_mem_in;

    // With zero wait states the access happens at the accept edge, using live inputs.
    assign cur_op    = (state_q == ST_IDLE) ? in_op    : op_q;
    assign cur_size  = (state_q == ST_IDLE) ? in_size  : size_q;
    assign cur_addr  = (state_q == ST_IDLE) ? in_addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? in_wdata : wdata_q;
    assign cur_ctrl  = (state_q == ST_IDLE) ? in_ctrl  : ctrl_q;

    assign lane = cur_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0];

    // State register and wait-state countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter WAIT on a memory op when wait states exist, leave when count hits 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_mem && !ZERO_WS) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(CNT_INIT);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: stall while waiting, access strobe and RAM write controls.
    always_comb begin
        stall     = (state_q == ST_WAIT);
        do_access = ZERO_WS ? accept_mem : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
        ram_wdata = cur_wdata;
        ram_we    = 2'b00;
        if (cur_size == SZ_BYTE) ram_wdata[15:8] = cur_wdata[7:0];
        // Gate with reset so an aborted access never reaches the array.
        if (do_access && (cur_op == OP_STORE) && rst) begin
            if (cur_size == SZ_WORD) ram_we = 2'b11;
            else                     ram_we = cur_addr[0] ? 2'b10 : 2'b01;
        end
    end

    // Capture operands when a memory op is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_PASS;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= '0;
        end else if (accept_mem) begin
            op_q    <= in_op;
            size_q  <= in_size;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            ctrl_q  <= in_ctrl;
        end
    end

    // Registered results toward MEM/WB; valid, ctrl and misalign are single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            byte_q  <= '0;
            octrl_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            octrl_q <= '0;
            mis_q   <= 1'b0;
            if (accept_pass) begin
                word_q  <= in_addr;
                octrl_q <= in_ctrl;
                valid_q <= 1'b1;
            end else if (do_access) begin
                valid_q <= 1'b1;
                octrl_q <= cur_ctrl;
                mis_q   <= (cur_size == SZ_WORD) && cur_addr[0];
                if (cur_op == OP_LOAD) begin
                    if (cur_size == SZ_WORD) begin
                        word_q <= ram_rdata;
                        byte_q <= ram_rdata[7:0];
                    end else begin
                        word_q <= {{(S-7){1'b0}}, lane};
                        byte_q <= lane;
                    end
                end else begin
                    word_q <= cur_addr;
                end
            end
        end
    end

    dmem_ram #(.S(S), .A(A)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .idx_i   (cur_addr[A:1]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign out_word  = word_q;
    assign out_byte  = byte_q;
    assign out_ctrl  = octrl_q;
    assign out_valid = valid_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench: a W=2 instance for the main tests and a W=0
// instance for back-to-back single-cycle accesses.
module tb_mem_access_stage;

    localparam int S = 15;
    localparam int C = 1;
    localparam int A = 6;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_size;
    logic [1:0]  in_op, in_ctrl;
    logic [15:0] in_addr, in_wdata;
    logic [15:0] out_word;
    logic [7:0]  out_byte;
    logic [1:0]  out_ctrl;
    logic        out_valid, stall, misalign;

    logic        z_valid, z_size;
    logic [1:0]  z_op, z_ctrl;
    logic [15:0] z_addr, z_wdata;
    logic [15:0] z_oword;
    logic [7:0]  z_obyte;
    logic [1:0]  z_octrl;
    logic        z_ovalid, z_stall, z_mis;

    mem_access_stage #(.S(S), .C(C), .A(A), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_size(in_size),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_ctrl(in_ctrl),
        .out_word(out_word), .out_byte(out_byte), .out_ctrl(out_ctrl),
        .out_valid(out_valid), .stall(stall), .misalign(misalign)
    );

    mem_access_stage #(.S(S), .C(C), .A(A), .W(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_valid), .in_op(z_op), .in_size(z_size),
        .in_addr(z_addr), .in_wdata(z_wdata), .in_ctrl(z_ctrl),
        .out_word(z_oword), .out_byte(z_obyte), .out_ctrl(z_octrl),
        .out_valid(z_ovalid), .stall(z_stall), .misalign(z_mis)
    );

    typedef struct {
        logic [15:0] word;
        logic [7:0]  byt;
        logic [1:0]  ctrl;
        logic        mis;
        int          lat;
        int          stl;
    } exp_t;

    exp_t        sbq[$];
    exp_t        z_q[$];
    logic [15:0] mem_m [64];
    logic [7:0]  byte_m;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction into the W=2 instance, then wait for and score its result.
    task automatic issue(input string tag, input logic [1:0] op, input logic sz,
                         input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] ct);
        exp_t e, r;
        int lat, stl;
        bit got, is_mem;
        logic [5:0] ix;
        logic [7:0] ln;
        ix     = addr[6:1];
        is_mem = (op == 2'b01) || (op == 2'b10);
        e.ctrl = ct;
        e.mis  = is_mem && !sz && addr[0];
        e.lat  = is_mem ? W + 1 : 1;
        e.stl  = is_mem ? W : 0;
        if (op == 2'b01) begin
            ln = addr[0] ? mem_m[ix][15:8] : mem_m[ix][7:0];
            if (!sz) begin
                e.word = mem_m[ix];
                byte_m = mem_m[ix][7:0];
            end else begin
                e.word = {8'h00, ln};
                byte_m = ln;
            end
        end else begin
            e.word = addr;
            if (op == 2'b10) begin
                if (!sz)          mem_m[ix]       = wd;
                else if (addr[0]) mem_m[ix][15:8] = wd[7:0];
                else              mem_m[ix][7:0]  = wd[7:0];
            end
        end
        e.byt = byte_m;
        sbq.push_back(e);

        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_size = sz; in_addr = addr; in_wdata = wd; in_ctrl = ct;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; stl = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (stall) stl++;
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        r = sbq.pop_front();
        if (got) begin
            chk({tag, "_word"},  {16'd0, out_word}, {16'd0, r.word});
            chk({tag, "_byte"},  {24'd0, out_byte}, {24'd0, r.byt});
            chk({tag, "_ctrl"},  {30'd0, out_ctrl}, {30'd0, r.ctrl});
            chk({tag, "_mis"},   {31'd0, misalign}, {31'd0, r.mis});
            chk({tag, "_lat"},   lat, r.lat);
            chk({tag, "_stall"}, stl, r.stl);
            @(negedge clk);
            chk({tag, "_vpulse"}, {30'd0, out_valid, |out_ctrl}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_op = 2'b00; in_size = 1'b0; in_addr = '0; in_wdata = '0; in_ctrl = '0;
        z_valid  = 1'b0; z_op  = 2'b00; z_size  = 1'b0; z_addr  = '0; z_wdata  = '0; z_ctrl  = '0;
        byte_m = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outs", {out_word, out_byte, out_ctrl, out_valid, stall, misalign}, 32'd0);
        chk("rst_outs0", {z_oword, z_obyte, z_octrl, z_ovalid, z_stall, z_mis}, 32'd0);
        rst = 1'b1;

        // Known content at 0x0004, then a store aborted by reset mid-wait.
        issue("pre_st", 2'b10, 1'b0, 16'h0004, 16'h1111, 2'b01);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b10; in_size = 1'b0; in_addr = 16'h0004; in_wdata = 16'h1234; in_ctrl = 2'b01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_outs", {out_word, out_byte, out_ctrl, out_valid, stall, misalign}, 32'd0);
        @(negedge clk);
        chk("abort_hold", {out_word, out_byte, out_ctrl, out_valid, stall, misalign}, 32'd0);
        rst = 1'b1;
        byte_m = 8'h00;
        issue("abort_ld", 2'b01, 1'b0, 16'h0004, 16'h0000, 2'b10);

        // Word store/load with wait states.
        issue("w_st", 2'b10, 1'b0, 16'h000A, 16'hBEEF, 2'b00);
        issue("w_ld", 2'b01, 1'b0, 16'h000A, 16'h0000, 2'b01);

        // Byte lanes.
        issue("b_stw", 2'b10, 1'b0, 16'h0010, 16'hA55A, 2'b00);
        issue("b_stb", 2'b10, 1'b1, 16'h0011, 16'h003C, 2'b00);
        issue("b_ld0", 2'b01, 1'b1, 16'h0010, 16'h0000, 2'b01);
        issue("b_ld1", 2'b01, 1'b1, 16'h0011, 16'h0000, 2'b01);
        issue("b_ldw", 2'b01, 1'b0, 16'h0010, 16'h0000, 2'b11);

        // Pass-through and reserved op.
        issue("pass", 2'b00, 1'b0, 16'h7F01, 16'hFFFF, 2'b11);
        issue("rsvd", 2'b11, 1'b1, 16'h0123, 16'h5555, 2'b10);

        // Misalign and address wrap.
        issue("m_st", 2'b10, 1'b0, 16'h0000, 16'hC0DE, 2'b00);
        issue("m_ld81", 2'b01, 1'b0, 16'h0081, 16'h0000, 2'b01);
        issue("m_ld80", 2'b01, 1'b0, 16'h0080, 16'h0000, 2'b01);

        // Zero-wait-state instance: alternating store/load every cycle.
        for (int i = 0; i <= 8; i++) begin
            exp_t e, r;
            @(negedge clk);
            if (i > 0) begin
                r = z_q.pop_front();
                chk("z_valid", {31'd0, z_ovalid}, 32'd1);
                chk("z_stall", {31'd0, z_stall}, 32'd0);
                chk("z_word", {16'd0, z_oword}, {16'd0, r.word});
                chk("z_ctrl", {30'd0, z_octrl}, {30'd0, r.ctrl});
            end
            if (i < 8) begin
                e.byt = 8'h00; e.mis = 1'b0; e.lat = 1; e.stl = 0;
                z_valid = 1'b1; z_size = 1'b0;
                if (i % 2 == 0) begin
                    z_op = 2'b10; z_addr = 16'(16'h0020 + 2 * i); z_wdata = 16'(16'h1000 + 16'h0111 * i);
                    z_ctrl = 2'b10;
                    e.word = z_addr;
                end else begin
                    z_op = 2'b01; z_ctrl = 2'b01;
                    e.word = z_wdata;
                end
                e.ctrl = z_ctrl;
                z_q.push_back(e);
            end else begin
                z_valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
